// File: rtl/jk_reg_counter.sv
// rtl/jk_reg_counter.sv - WIDTH-bit JK register with parallel load and up/down toggle-chain counter
// Optional: define JK_REG_COUNTER_SATURATE_EN to make count modes saturate at the limits instead of wrapping.
module jk_reg_counter #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc
);

   localparam logic [1:0] MODE_JK   = 2'b00;
   localparam logic [1:0] MODE_LOAD = 2'b01;
   localparam logic [1:0] MODE_UP   = 2'b10;
   localparam logic [1:0] MODE_DOWN = 2'b11;

   logic [WIDTH-1:0] r_q;
   logic             r_tc;
   logic [WIDTH-1:0] w_up_tog;
   logic [WIDTH-1:0] w_dn_tog;
   logic [WIDTH-1:0] w_next;
   logic             w_tc;
   logic             w_all_ones;
   logic             w_all_zero;

   // Toggle chain: a bit flips when every lower bit is 1 (up) or 0 (down).
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_chain
         if (gi == 0) begin : g_lsb
            assign w_up_tog[gi] = 1'b1;
            assign w_dn_tog[gi] = 1'b1;
         end else begin : g_upper
            assign w_up_tog[gi] = &r_q[gi-1:0];
            assign w_dn_tog[gi] = ~|r_q[gi-1:0];
         end
      end
   endgenerate

   assign w_all_ones = &r_q;
   assign w_all_zero = ~|r_q;

   always_comb begin
      w_next = r_q;
      w_tc   = 1'b0;
      case (mode)
         MODE_JK: begin
            for (int i = 0; i < WIDTH; i++) begin
               case ({j[i], k[i]})
                  2'b01:   w_next[i] = 1'b0;
                  2'b10:   w_next[i] = 1'b1;
                  2'b11:   w_next[i] = ~r_q[i];
                  default: w_next[i] = r_q[i];
               endcase
            end
         end
         MODE_LOAD: w_next = d;
         MODE_UP: begin
            w_tc = w_all_ones;
`ifdef JK_REG_COUNTER_SATURATE_EN
            w_next = w_all_ones ? r_q : (r_q ^ w_up_tog);
`else
            w_next = r_q ^ w_up_tog;
`endif
         end
         MODE_DOWN: begin
            w_tc = w_all_zero;
`ifdef JK_REG_COUNTER_SATURATE_EN
            w_next = w_all_zero ? r_q : (r_q ^ w_dn_tog);
`else
            w_next = r_q ^ w_dn_tog;
`endif
         end
         default: w_next = r_q;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_q  <= RESET_VAL;
         r_tc <= 1'b0;
      end else if (en) begin
         r_q  <= w_next;
         r_tc <= w_tc;
      end else begin
         r_tc <= 1'b0;
      end
   end

   assign q  = r_q;
   assign tc = r_tc;

endmodule
